alu: RTL and testbench



---
 rtl/alu_if.sv | 39 +++
 rtl/alu.sv | 139 +++++++++++++
 tb/tb_alu.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ALU operand/result bundle: operands and op code in, comb and
// registered status out. master drives operands, slave is the ALU.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

  modport master (
    output in1,
    output in2,
    output ctl,
    input  result,
    input  zero,
    input  overflow,
    input  result_q,
    input  zero_q,
    input  ovf_q
  );

  modport slave (
    input  in1,
    input  in2,
    input  ctl,
    output result,
    output zero,
    output overflow,
    output result_q,
    output zero_q,
    output ovf_q
  );
endinterface

// File: rtl/alu.sv
// Integer ALU: comb result/zero/overflow plus a 1-cycle status copy.
// Ports: clk, rst_n (sync, active-low), bus (alu_if.slave).
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int M  = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_ctl;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic             w_sltu;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_zero;

  logic w_is_and;
  logic w_is_or;
  logic w_is_add;
  logic w_is_xor;
  logic w_is_sll;
  logic w_is_srl;
  logic w_is_sub;
  logic w_is_slt;
  logic w_is_sra;
  logic w_is_sltu;
  logic w_is_nor;

  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_ovf;

  assign w_a   = bus.in1;
  assign w_b   = bus.in2;
  assign w_ctl = bus.ctl;
  assign w_sh  = w_b[SW-1:0];

  // Carry out of both adders is dropped.
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  assign w_add_ovf = (w_a[M] == w_b[M]) &&
                     (w_sum[M] != w_a[M]);
  assign w_sub_ovf = (w_a[M] != w_b[M]) &&
                     (w_diff[M] != w_a[M]);

  // True signed compare, so SLT stays right
  // when the subtraction overflows.
  assign w_slt  = $signed(w_a) < $signed(w_b);
  assign w_sltu = w_a < w_b;

  assign w_is_and  = (w_ctl == OP_AND);
  assign w_is_or   = (w_ctl == OP_OR);
  assign w_is_add  = (w_ctl == OP_ADD);
  assign w_is_xor  = (w_ctl == OP_XOR);
  assign w_is_sll  = (w_ctl == OP_SLL);
  assign w_is_srl  = (w_ctl == OP_SRL);
  assign w_is_sub  = (w_ctl == OP_SUB);
  assign w_is_slt  = (w_ctl == OP_SLT);
  assign w_is_sra  = (w_ctl == OP_SRA);
  assign w_is_sltu = (w_ctl == OP_SLTU);
  assign w_is_nor  = (w_ctl == OP_NOR);

  // Unknown op codes fall to the defaults:
  // result 0, overflow 0.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (1'b1)
      w_is_and:  w_res = w_a & w_b;
      w_is_or:   w_res = w_a | w_b;
      w_is_add: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      w_is_xor:  w_res = w_a ^ w_b;
      w_is_sll:  w_res = w_a << w_sh;
      w_is_srl:  w_res = w_a >> w_sh;
      w_is_sub: begin
        w_res = w_diff;
        w_ovf = w_sub_ovf;
      end
      w_is_slt:  w_res = {{M{1'b0}}, w_slt};
      w_is_sra:
        w_res = $unsigned($signed(w_a) >>> w_sh);
      w_is_sltu: w_res = {{M{1'b0}}, w_sltu};
      w_is_nor:  w_res = ~(w_a | w_b);
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  assign w_zero = ~|w_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_zero <= 1'b1;
      r_ovf  <= 1'b0;
    end else begin
      r_res  <= w_res;
      r_zero <= w_zero;
      r_ovf  <= w_ovf;
    end
  end

  assign bus.result   = w_res;
  assign bus.zero     = w_zero;
  assign bus.overflow = w_ovf;
  assign bus.result_q = r_res;
  assign bus.zero_q   = r_zero;
  assign bus.ovf_q    = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors, reset checks, random ops,
// all compared against an arithmetic reference model.
module tb_alu;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain signed/unsigned 64-bit arithmetic.
  function automatic void model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   c,
    output logic [W-1:0] r,
    output logic         z,
    output logic         o
  );
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint t;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = int'(b[4:0]);
    r  = '0;
    o  = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        t = sa + sb;
        r = t[31:0];
        o = (t > 64'sd2147483647) ||
            (t < -64'sd2147483648);
      end
      4'b0110: begin
        t = sa - sb;
        r = t[31:0];
        o = (t > 64'sd2147483647) ||
            (t < -64'sd2147483648);
      end
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1001: r = (ua < ub) ? 1 : 0;
      4'b0100: begin
        t = ua << sh;
        r = t[31:0];
      end
      4'b0101: begin
        t = ua >> sh;
        r = t[31:0];
      end
      4'b1000: begin
        t = sa >>> sh;
        r = t[31:0];
      end
      default: r = '0;
    endcase
    z = (r == 0);
  endfunction

  task automatic chk(
    input string        nm,
    input logic [W-1:0] act,
    input logic [W-1:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Expected registered status, updated at each edge.
  logic [W-1:0] eq_r;
  logic         eq_z;
  logic         eq_o;
  logic         q_ok;

  initial q_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      eq_r = '0;
      eq_z = 1'b1;
      eq_o = 1'b0;
    end else begin
      model(bus.in1, bus.in2, bus.ctl,
            eq_r, eq_z, eq_o);
    end
    q_ok = 1'b1;
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [W-1:0] mr;
    logic         mz;
    logic         mo;
    model(bus.in1, bus.in2, bus.ctl, mr, mz, mo);
    chk("result", bus.result, mr);
    chk("zero", 32'(bus.zero), 32'(mz));
    chk("overflow", 32'(bus.overflow), 32'(mo));
    if (q_ok) begin
      chk("result_q", bus.result_q, eq_r);
      chk("zero_q", 32'(bus.zero_q), 32'(eq_z));
      chk("ovf_q", 32'(bus.ovf_q), 32'(eq_o));
    end
  end

  task automatic vec(
    input string        nm,
    input logic [3:0]   c,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] er,
    input logic         ez,
    input logic         eo
  );
    logic [W-1:0] mr;
    logic         mz;
    logic         mo;
    @(posedge clk);
    #1;
    bus.ctl = c;
    bus.in1 = a;
    bus.in2 = b;
    #2;
    chk({nm, "_res"}, bus.result, er);
    chk({nm, "_z"}, 32'(bus.zero), 32'(ez));
    chk({nm, "_o"}, 32'(bus.overflow), 32'(eo));
    model(a, b, c, mr, mz, mo);
    chk({nm, "_mdl"}, mr, er);
    chk({nm, "_mdlo"}, 32'(mo), 32'(eo));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.ctl = 4'b0010;
    bus.in1 = 32'd3;
    bus.in2 = 32'd4;

    @(posedge clk);
    #1;
    chk("rst_res_q", bus.result_q, 32'h0);
    chk("rst_zero_q", 32'(bus.zero_q), 32'h1);
    chk("rst_ovf_q", 32'(bus.ovf_q), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_res_q", bus.result_q, 32'd7);
    chk("rel_zero_q", 32'(bus.zero_q), 32'h0);

    vec("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1,
        32'h0, 1'b1, 1'b0);
    vec("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1,
        32'h80000000, 1'b0, 1'b1);
    vec("sub_ovf", 4'b0110, 32'h80000000, 32'h1,
        32'h7FFFFFFF, 1'b0, 1'b1);
    vec("sub_eq", 4'b0110, 32'h1234, 32'h1234,
        32'h0, 1'b1, 1'b0);
    vec("and", 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0,
        32'h00F000F0, 1'b0, 1'b0);
    vec("or", 4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0,
        32'hFFF0FFF0, 1'b0, 1'b0);
    vec("xor", 4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0,
        32'hFF00FF00, 1'b0, 1'b0);
    vec("nor", 4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0,
        32'h000F000F, 1'b0, 1'b0);
    vec("slt", 4'b0111, 32'hFFFFFFFF, 32'h1,
        32'h1, 1'b0, 1'b0);
    vec("sltu", 4'b1001, 32'hFFFFFFFF, 32'h1,
        32'h0, 1'b1, 1'b0);
    vec("slt_ov", 4'b0111, 32'h80000000, 32'h1,
        32'h1, 1'b0, 1'b0);
    vec("sra35", 4'b1000, 32'h80000000, 32'd35,
        32'hF0000000, 1'b0, 1'b0);
    vec("srl35", 4'b0101, 32'h80000000, 32'd35,
        32'h10000000, 1'b0, 1'b0);
    vec("sll33", 4'b0100, 32'h80000003, 32'd33,
        32'h00000006, 1'b0, 1'b0);
    vec("sll0", 4'b0100, 32'hDEADBEEF, 32'h20,
        32'hDEADBEEF, 1'b0, 1'b0);
    vec("sra0", 4'b1000, 32'h8000_0001, 32'h0,
        32'h80000001, 1'b0, 1'b0);
    vec("undef", 4'b1111, 32'h12345678, 32'h9,
        32'h0, 1'b1, 1'b0);
    vec("undef_a", 4'b1010, 32'hFFFFFFFF, 32'h1,
        32'h0, 1'b1, 1'b0);

    // Reset pulse in the middle of traffic.
    vec("pre_rst", 4'b0010, 32'd10, 32'd20,
        32'd30, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_q", bus.result_q, 32'h0);
    chk("mid_rst_z", 32'(bus.zero_q), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_q", bus.result_q, 32'd30);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ops [12];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
              4'b0011, 4'b1100, 4'b0111, 4'b1001,
              4'b0100, 4'b0101, 4'b1000, 4'b1110};
      @(posedge clk);
      #1;
      bus.ctl = ops[$urandom_range(0, 11)];
      bus.in1 = $urandom;
      bus.in2 = $urandom;
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
